// File: rtl/ps_pkg.sv
// Shared types for the hardware-loop program sequencer: loop frame record and
// next-address select encoding.
package ps_pkg;

  // Frame fields are sized for the largest supported address/count widths;
  // the top level zero-extends into them and truncates back out.
  localparam int unsigned PS_ADDR_MAX = 32;
  localparam int unsigned PS_CNT_MAX  = 32;

  typedef logic [PS_ADDR_MAX-1:0] frame_addr_t;
  typedef logic [PS_CNT_MAX-1:0]  frame_cnt_t;

  typedef struct packed {
    frame_addr_t start;
    frame_addr_t end_addr;
    frame_cnt_t  remaining;
    logic        valid;
  } loop_frame_t;

  typedef enum logic [1:0] {
    NEXT_RST,
    NEXT_JMP,
    NEXT_LOOP,
    NEXT_INC
  } next_sel_t;

endpackage

// File: rtl/ps_loop_stack.sv
// Nested loop-frame stack. Entry 0 is always the innermost (top) frame;
// pop/decrement are applied before a same-cycle push.
module ps_loop_stack
  import ps_pkg::*;
#(
  parameter int unsigned LOOP_DEPTH = 4,
  parameter int unsigned LVL_W      = $clog2(LOOP_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             dec,
  input  loop_frame_t      new_frame,
  output loop_frame_t      top_frame,
  output logic [LVL_W-1:0] level,
  output logic             ovf
);

  loop_frame_t      frames     [LOOP_DEPTH];
  loop_frame_t      frames_nxt [LOOP_DEPTH];
  logic [LVL_W-1:0] level_nxt;
  logic             ovf_nxt;

  always_comb begin
    frames_nxt = frames;
    level_nxt  = level;
    ovf_nxt    = ovf;
    if (dec) begin
      frames_nxt[0].remaining = frames[0].remaining - frame_cnt_t'(1);
    end
    if (pop) begin
      for (int unsigned i = 0; i + 1 < LOOP_DEPTH; i++) begin
        frames_nxt[i] = frames_nxt[i+1];
      end
      frames_nxt[LOOP_DEPTH-1] = '0;
      level_nxt = level_nxt - LVL_W'(1);
    end
    // Fullness is judged after the pop so a same-cycle pop+push always fits.
    if (push) begin
      if (level_nxt == LVL_W'(LOOP_DEPTH)) begin
        ovf_nxt = 1'b1;
      end else begin
        for (int unsigned i = LOOP_DEPTH - 1; i > 0; i--) begin
          frames_nxt[i] = frames_nxt[i-1];
        end
        frames_nxt[0] = new_frame;
        level_nxt = level_nxt + LVL_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frames <= '{default: '0};
      level  <= '0;
      ovf    <= 1'b0;
    end else begin
      frames <= frames_nxt;
      level  <= level_nxt;
      ovf    <= ovf_nxt;
    end
  end

  assign top_frame = frames[0];

endmodule

// File: rtl/program_sequencer_hwloop.sv
// Program sequencer with jmp/jmp_nz and a nested hardware-loop stack.
// Optional feature macro: PS_LOOP_BREAK_EN adds the loop_break input.
module program_sequencer_hwloop
  import ps_pkg::*;
#(
  parameter int unsigned PM_AW      = 8,
  parameter int unsigned JA_W       = 4,
  parameter int unsigned LOOP_DEPTH = 4,
  parameter int unsigned LEN_W      = 4,
  parameter int unsigned CNT_W      = 8
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               jmp,
  input  logic                               jmp_nz,
  input  logic                               dont_jmp,
  input  logic [JA_W-1:0]                    jmp_addr,
  input  logic                               loop_start,
  input  logic [LEN_W-1:0]                   loop_len,
  input  logic [CNT_W-1:0]                   loop_cnt,
`ifdef PS_LOOP_BREAK_EN
  input  logic                               loop_break,
`endif
  output logic [PM_AW-1:0]                   pm_addr,
  output logic [PM_AW-1:0]                   pc,
  output logic [$clog2(LOOP_DEPTH+1)-1:0]    loop_level,
  output logic                               loop_ovf
);

  localparam int unsigned LVL_W = $clog2(LOOP_DEPTH + 1);

  loop_frame_t      top_frame;
  loop_frame_t      new_frame;
  next_sel_t        sel;
  logic             push, pop, dec;
  logic             jump_taken, at_end, brk;
  logic [PM_AW-1:0] pc_inc, pc_end;

  assign pc_inc     = pc + PM_AW'(1);
  assign pc_end     = pc + PM_AW'(loop_len);
  assign jump_taken = jmp | (jmp_nz & ~dont_jmp);
  assign at_end     = top_frame.valid && (top_frame.end_addr == frame_addr_t'(pc));
  assign push       = loop_start && (loop_len != '0);

`ifdef PS_LOOP_BREAK_EN
  assign brk = loop_break & top_frame.valid;
`else
  assign brk = 1'b0;
`endif

  always_comb begin
    new_frame           = '0;
    new_frame.start     = frame_addr_t'(pc_inc);
    new_frame.end_addr  = frame_addr_t'(pc_end);
    new_frame.remaining = (loop_cnt == '0) ? frame_cnt_t'(1) : frame_cnt_t'(loop_cnt);
    new_frame.valid     = 1'b1;
  end

  // A taken jump leaves the stack untouched, even at a loop end address.
  always_comb begin
    sel = NEXT_INC;
    pop = 1'b0;
    dec = 1'b0;
    if (reset) begin
      sel = NEXT_RST;
    end else if (jump_taken) begin
      sel = NEXT_JMP;
    end else if (brk) begin
      sel = NEXT_LOOP;
      pop = 1'b1;
    end else if (at_end) begin
      if (top_frame.remaining > frame_cnt_t'(1)) begin
        sel = NEXT_LOOP;
        dec = 1'b1;
      end else begin
        pop = 1'b1;
      end
    end
  end

  always_comb begin
    pm_addr = '0;
    unique case (sel)
      NEXT_RST:  pm_addr = '0;
      NEXT_JMP:  pm_addr = PM_AW'(jmp_addr) << (PM_AW - JA_W);
      NEXT_LOOP: pm_addr = brk ? PM_AW'(top_frame.end_addr) + PM_AW'(1)
                               : PM_AW'(top_frame.start);
      default:   pm_addr = pc_inc;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc <= '0;
    end else begin
      pc <= pm_addr;
    end
  end

  ps_loop_stack #(
    .LOOP_DEPTH (LOOP_DEPTH),
    .LVL_W      (LVL_W)
  ) u_stack (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .dec       (dec),
    .new_frame (new_frame),
    .top_frame (top_frame),
    .level     (loop_level),
    .ovf       (loop_ovf)
  );

endmodule

// File: tb/tb_program_sequencer_hwloop.sv
// Self-checking bench for program_sequencer_hwloop against a queue-based loop model.
module tb_program_sequencer_hwloop;

  localparam int unsigned PM_AW      = 8;
  localparam int unsigned JA_W       = 4;
  localparam int unsigned LOOP_DEPTH = 4;
  localparam int unsigned LEN_W      = 4;
  localparam int unsigned CNT_W      = 8;
`ifdef PS_LOOP_BREAK_EN
  localparam bit BREAK_EN = 1'b1;
`else
  localparam bit BREAK_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             jmp = 1'b0, jmp_nz = 1'b0, dont_jmp = 1'b0, loop_start = 1'b0;
  logic [JA_W-1:0]  jmp_addr = '0;
  logic [LEN_W-1:0] loop_len = '0;
  logic [CNT_W-1:0] loop_cnt = '0;
`ifdef PS_LOOP_BREAK_EN
  logic             loop_break = 1'b0;
`endif
  logic [PM_AW-1:0] pm_addr, pc;
  logic [2:0]       loop_level;
  logic             loop_ovf;

  program_sequencer_hwloop #(
    .PM_AW(PM_AW), .JA_W(JA_W), .LOOP_DEPTH(LOOP_DEPTH), .LEN_W(LEN_W), .CNT_W(CNT_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .jmp        (jmp),
    .jmp_nz     (jmp_nz),
    .dont_jmp   (dont_jmp),
    .jmp_addr   (jmp_addr),
    .loop_start (loop_start),
    .loop_len   (loop_len),
    .loop_cnt   (loop_cnt),
`ifdef PS_LOOP_BREAK_EN
    .loop_break (loop_break),
`endif
    .pm_addr    (pm_addr),
    .pc         (pc),
    .loop_level (loop_level),
    .loop_ovf   (loop_ovf)
  );

  always #5 clk = ~clk;

  int unsigned passed = 0;
  int unsigned total  = 0;

  // Model state: program counter, loop frames as parallel queues (back = innermost).
  int unsigned m_pc;
  int unsigned q_start[$], q_end[$], q_rem[$];
  bit          m_ovf;

  bit          ls_tab  [256];
  int unsigned len_tab [256];
  int unsigned cnt_tab [256];
  int unsigned pc_hist[$], lvl_hist[$];

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at time %0t", name, act, exp, $time);
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 256; i++) begin
      ls_tab[i] = 1'b0; len_tab[i] = 0; cnt_tab[i] = 0;
    end
  endtask

  task automatic model_pop();
    void'(q_start.pop_back());
    void'(q_end.pop_back());
    void'(q_rem.pop_back());
  endtask

  task automatic model_step(input bit j, input bit jn, input bit dz, input int unsigned ja,
                            input bit brk, input bit ls, input int unsigned len,
                            input int unsigned cnt, output int unsigned nxt);
    int unsigned n;
    n = q_end.size();
    if (j || (jn && !dz)) begin
      nxt = (ja << (PM_AW - JA_W)) % 256;
    end else if (brk && BREAK_EN && n > 0) begin
      nxt = (q_end[n-1] + 1) % 256;
      model_pop();
    end else if (n > 0 && m_pc == q_end[n-1]) begin
      if (q_rem[n-1] > 1) begin
        nxt = q_start[n-1];
        q_rem[n-1] = q_rem[n-1] - 1;
      end else begin
        nxt = (m_pc + 1) % 256;
        model_pop();
      end
    end else begin
      nxt = (m_pc + 1) % 256;
    end
    if (ls && len != 0) begin
      if (q_end.size() == LOOP_DEPTH) m_ovf = 1'b1;
      else begin
        q_start.push_back((m_pc + 1) % 256);
        q_end.push_back((m_pc + len) % 256);
        q_rem.push_back(cnt == 0 ? 1 : cnt);
      end
    end
    m_pc = nxt;
  endtask

  // Starts and ends at a falling edge; outputs are compared 1ns after inputs change.
  task automatic cycle(input bit rnd, input bit j, input bit jn, input bit dz,
                       input int unsigned ja, input bit brk, output int unsigned pm_seen);
    bit          ls, cur_ovf;
    int unsigned len, cnt, exp_pm, cur_pc, cur_lvl;
    if (rnd) begin
      ls  = ($urandom_range(0, 5) == 0);
      len = $urandom_range(0, 15);
      cnt = $urandom_range(0, 4);
      j   = ($urandom_range(0, 40) == 0);
      jn  = ($urandom_range(0, 20) == 0);
      dz  = $urandom_range(0, 1);
      ja  = $urandom_range(0, 15);
      brk = BREAK_EN && ($urandom_range(0, 30) == 0);
    end else begin
      ls = ls_tab[m_pc]; len = len_tab[m_pc]; cnt = cnt_tab[m_pc];
    end
    jmp = j; jmp_nz = jn; dont_jmp = dz; jmp_addr = ja[JA_W-1:0];
    loop_start = ls; loop_len = len[LEN_W-1:0]; loop_cnt = cnt[CNT_W-1:0];
`ifdef PS_LOOP_BREAK_EN
    loop_break = brk;
`endif
    #1;
    cur_pc = m_pc; cur_lvl = q_end.size(); cur_ovf = m_ovf;
    model_step(j, jn, dz, ja, brk, ls, len, cnt, exp_pm);
    chk("pc", pc, cur_pc);
    chk("loop_level", loop_level, cur_lvl);
    chk("loop_ovf", loop_ovf, cur_ovf);
    chk("pm_addr", pm_addr, exp_pm);
    pc_hist.push_back(pc);
    lvl_hist.push_back(loop_level);
    pm_seen = pm_addr;
    @(negedge clk);
  endtask

  // Asserted mid-cycle: effects must be visible before the next rising edge.
  task automatic do_reset();
    reset = 1'b1;
    jmp = 1'b0; jmp_nz = 1'b0; loop_start = 1'b0;
    #1;
    chk("rst_pc", pc, 0);
    chk("rst_pm_addr", pm_addr, 0);
    chk("rst_level", loop_level, 0);
    chk("rst_ovf", loop_ovf, 0);
    m_pc = 0; m_ovf = 1'b0;
    q_start.delete(); q_end.delete(); q_rem.delete();
    pc_hist.delete(); lvl_hist.delete();
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int unsigned pm, guard;
    int unsigned seq2[$];
    int unsigned seq3[$];
    seq2 = '{3, 4, 5, 4, 5, 4, 5, 6};
    seq3 = '{2, 3, 4, 5, 4, 5, 6, 7, 8, 3, 4, 5, 4, 5, 6, 7, 8, 9};

    clear_prog();
    @(negedge clk);
    do_reset();

    // Free run with wrap
    for (int i = 0; i < 258; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, pm);
    chk("wrap_255", pc_hist[255], 255);
    chk("wrap_0", pc_hist[256], 0);

    // Single loop at 3, len 2, cnt 3
    clear_prog();
    ls_tab[3] = 1'b1; len_tab[3] = 2; cnt_tab[3] = 3;
    do_reset();
    for (int i = 0; i < 11; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, pm);
    for (int k = 0; k < 8; k++) chk("t2_seq", pc_hist[3+k], seq2[k]);
    chk("t2_level_in_loop", lvl_hist[4], 1);
    chk("t2_level_after", lvl_hist[10], 0);

    // Nested loops
    clear_prog();
    ls_tab[2] = 1'b1; len_tab[2] = 6; cnt_tab[2] = 2;
    ls_tab[3] = 1'b1; len_tab[3] = 2; cnt_tab[3] = 2;
    do_reset();
    for (int i = 0; i < 20; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, pm);
    for (int k = 0; k < 18; k++) chk("t3_seq", pc_hist[2+k], seq3[k]);

    // Jump at loop end wins over loop-back
    clear_prog();
    ls_tab[3] = 1'b1; len_tab[3] = 2; cnt_tab[3] = 3;
    do_reset();
    guard = 0;
    while (m_pc != 5 && guard < 20) begin
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, pm);
      guard++;
    end
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 4'hA, 1'b0, pm);
    chk("t4_jump_pm_addr", pm, 8'hA0);
    chk("t4_level_at_jump", lvl_hist[lvl_hist.size()-1], 1);
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 4'h3, 1'b0, pm);
    chk("t4_pc_after_jump", pc_hist[pc_hist.size()-1], 8'hA0);
    chk("t4_level_after_jump", lvl_hist[lvl_hist.size()-1], 1);
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, pm);

    // Overflow then async reset mid-loop
    clear_prog();
    for (int p = 1; p <= 5; p++) begin
      ls_tab[p] = 1'b1; len_tab[p] = 16 - 2 * p; cnt_tab[p] = 2;
    end
    do_reset();
    for (int i = 0; i < 7; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, pm);
    chk("t5_ovf", loop_ovf, 1);
    chk("t5_level_full", loop_level, LOOP_DEPTH);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, pm);
    do_reset();
    for (int i = 0; i < 30; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, pm);

`ifdef PS_LOOP_BREAK_EN
    clear_prog();
    ls_tab[3] = 1'b1; len_tab[3] = 4; cnt_tab[3] = 5;
    do_reset();
    guard = 0;
    while (m_pc != 5 && guard < 20) begin
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, pm);
      guard++;
    end
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1, pm);
    chk("t6_break_pm_addr", pm, 8);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, pm);
    chk("t6_break_level", lvl_hist[lvl_hist.size()-1], 0);
`endif

    // Randomized traffic against the model
    clear_prog();
    for (int r = 0; r < 6; r++) begin
      do_reset();
      for (int i = 0; i < 500; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0, pm);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
